// File: rtl/dual_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dual_issue_queue                                                |
// | Purpose  : Circular instruction queue between the dual decoder and the     |
// |            dispatch stage. Accepts 0-2 entries per cycle in program order, |
// |            presents the two oldest entries and retires 0-2 per cycle.      |
// | Ports    : clk, rst (async, active-low)                                    |
// |            flush      - synchronous clear, overrides push and pop          |
// |            pause      - blocks retirement only                             |
// |            push_valid/push_data/push_ready - decode side, lane0 older      |
// |            issue_en   - dispatch grant (01: head, 11: head+1, 10: none)    |
// |            out_valid/out_data - head (lane0) and head+1 (lane1)            |
// |            count      - current occupancy                                  |
// | Options  : DIQ_PERF_CNT_EN adds perf_full_cycles / perf_single_issue       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dual_issue_queue #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   pause,
   input  logic [1:0]             push_valid,
   input  logic [2*ENTRY_W-1:0]   push_data,
   output logic                   push_ready,
   input  logic [1:0]             issue_en,
   output logic [1:0]             out_valid,
   output logic [2*ENTRY_W-1:0]   out_data,
   output logic [$clog2(DEPTH):0] count
`ifdef DIQ_PERF_CNT_EN
   ,
   output logic [31:0]            perf_full_cycles,
   output logic [31:0]            perf_single_issue
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Accept a push only while at least two slots are free, judged before this
   // cycle's pop so the ready path never depends on the dispatch grant.
   localparam logic [CW-1:0] c_push_lim = CW'(DEPTH - 2);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_cnt;

   logic               w_push_ready;
   logic [1:0]         w_n_push;
   logic [1:0]         w_req;
   logic [1:0]         w_n_pop;
   logic [PW-1:0]      w_tail1;
   logic [ENTRY_W-1:0] w_wdata0;
   logic [ENTRY_W-1:0] w_wdata1;

   assign w_push_ready = (r_cnt <= c_push_lim);
   assign w_n_push     = w_push_ready ? ({1'b0, push_valid[0]} + {1'b0, push_valid[1]}) : 2'd0;

   // 2'b10 is not a legal grant and retires nothing.
   assign w_req = (issue_en == 2'b11) ? 2'd2 : (issue_en[0] ? 2'd1 : 2'd0);

   always_comb begin
      w_n_pop = 2'd0;
      if (!pause) begin
         if (r_cnt < CW'(w_req)) begin
            w_n_pop = r_cnt[1:0];
         end else begin
            w_n_pop = w_req;
         end
      end
   end

   // Compact valid lanes: a lone lane1 entry lands at the tail slot.
   assign w_tail1  = r_tail + PW'(1);
   assign w_wdata0 = push_valid[0] ? push_data[0 +: ENTRY_W] : push_data[ENTRY_W +: ENTRY_W];
   assign w_wdata1 = push_data[ENTRY_W +: ENTRY_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else if (flush) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_head <= r_head + PW'(w_n_pop);
         r_tail <= r_tail + PW'(w_n_push);
         r_cnt  <= r_cnt - CW'(w_n_pop) + CW'(w_n_push);
      end
   end

   // Storage carries no reset; occupancy alone qualifies its contents.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (w_n_push != 2'd0) begin
            r_mem[r_tail] <= w_wdata0;
         end
         if (w_n_push == 2'd2) begin
            r_mem[w_tail1] <= w_wdata1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         assign out_data[gi*ENTRY_W +: ENTRY_W] = r_mem[r_head + PW'(gi)];
      end
   endgenerate

   assign out_valid  = {(r_cnt >= CW'(2)), (r_cnt != '0)};
   assign push_ready = w_push_ready;
   assign count      = r_cnt;

`ifdef DIQ_PERF_CNT_EN
   logic [31:0] r_perf_full;
   logic [31:0] r_perf_single;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_full   <= '0;
         r_perf_single <= '0;
      end else begin
         if ((push_valid != 2'b00) && !w_push_ready && (r_perf_full != 32'hFFFF_FFFF)) begin
            r_perf_full <= r_perf_full + 32'd1;
         end
         // A flush cancels the pop, so it does not count as a single issue.
         if (!flush && (w_n_pop == 2'd1) && (r_cnt >= CW'(2)) &&
             (r_perf_single != 32'hFFFF_FFFF)) begin
            r_perf_single <= r_perf_single + 32'd1;
         end
      end
   end

   assign perf_full_cycles  = r_perf_full;
   assign perf_single_issue = r_perf_single;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dual_issue_queue                                             |
// | Purpose  : Scoreboard bench for dual_issue_queue against a queue-based     |
// |            reference model; directed scenarios followed by random traffic. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dual_issue_queue;

   localparam int DEPTH   = 8;
   localparam int ENTRY_W = 128;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 flush = 1'b0;
   logic                 pause = 1'b0;
   logic [1:0]           push_valid = 2'b00;
   logic [2*ENTRY_W-1:0] push_data = '0;
   logic                 push_ready;
   logic [1:0]           issue_en = 2'b00;
   logic [1:0]           out_valid;
   logic [2*ENTRY_W-1:0] out_data;
   logic [3:0]           count;
`ifdef DIQ_PERF_CNT_EN
   logic [31:0]          perf_full_cycles;
   logic [31:0]          perf_single_issue;
`endif

   dual_issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .pause      (pause),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .issue_en   (issue_en),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .count      (count)
`ifdef DIQ_PERF_CNT_EN
      ,
      .perf_full_cycles  (perf_full_cycles),
      .perf_single_issue (perf_single_issue)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]         ov;
      logic [3:0]         cnt;
      logic               pr;
      logic [ENTRY_W-1:0] d0;
      logic [ENTRY_W-1:0] d1;
      logic [31:0]        pf;
      logic [31:0]        ps;
   } exp_t;

   exp_t               expq[$];
   logic [ENTRY_W-1:0] mq[$];   // reference queue, front = oldest
   logic [31:0]        m_pf = 0;
   logic [31:0]        m_ps = 0;
   int                 n_cmp = 0;
   int                 n_err = 0;

   task automatic chk(input string nm, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [ENTRY_W-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One cycle: record what the outputs must show now, then apply new inputs
   // and advance the model to the state after the coming clock edge.
   task automatic step(input logic rs, input logic [1:0] pv, input logic [ENTRY_W-1:0] a,
                       input logic [ENTRY_W-1:0] b, input logic [1:0] ie, input logic ps,
                       input logic fl);
      exp_t e;
      int   n, req, np;
      bit   pr;
      @(posedge clk);
      #1;
      rst = rs;
      if (!rs) begin
         mq.delete();
         m_pf = 0;
         m_ps = 0;
      end
      n      = mq.size();
      pr     = (DEPTH - n) >= 2;
      e.ov   = {n >= 2, n >= 1};
      e.cnt  = 4'(n);
      e.pr   = pr;
      e.d0   = (n >= 1) ? mq[0] : '0;
      e.d1   = (n >= 2) ? mq[1] : '0;
      e.pf   = m_pf;
      e.ps   = m_ps;
      expq.push_back(e);

      push_valid = pv;
      push_data  = {b, a};
      issue_en   = ie;
      pause      = ps;
      flush      = fl;

      if (rs) begin
         req = (ie == 2'b11) ? 2 : (ie == 2'b01) ? 1 : 0;
         np  = ps ? 0 : ((req < n) ? req : n);
         if ((pv != 2'b00) && !pr && (m_pf != 32'hFFFF_FFFF)) m_pf++;
         if (fl) begin
            mq.delete();
         end else begin
            if ((np == 1) && (n >= 2) && (m_ps != 32'hFFFF_FFFF)) m_ps++;
            repeat (np) void'(mq.pop_front());
            if (pr) begin
               if (pv[0]) mq.push_back(a);
               if (pv[1]) mq.push_back(b);
            end
         end
      end
   endtask

   task automatic push2(input logic [1:0] pv);
      step(1'b1, pv, rnd_data(), rnd_data(), 2'b00, 1'b0, 1'b0);
   endtask

   task automatic pop(input logic [1:0] ie);
      step(1'b1, 2'b00, '0, '0, ie, 1'b0, 1'b0);
   endtask

   // Monitor: compares every recorded expectation against the outputs,
   // sampled mid-cycle well away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #6;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("count", ENTRY_W'(count), ENTRY_W'(e.cnt));
            chk("out_valid", ENTRY_W'(out_valid), ENTRY_W'(e.ov));
            chk("push_ready", ENTRY_W'(push_ready), ENTRY_W'(e.pr));
            if (e.ov[0]) chk("out_data0", out_data[0 +: ENTRY_W], e.d0);
            if (e.ov[1]) chk("out_data1", out_data[ENTRY_W +: ENTRY_W], e.d1);
`ifdef DIQ_PERF_CNT_EN
            chk("perf_full", ENTRY_W'(perf_full_cycles), ENTRY_W'(e.pf));
            chk("perf_single", ENTRY_W'(perf_single_issue), ENTRY_W'(e.ps));
`endif
         end
      end
   end

   initial begin
      logic [ENTRY_W-1:0] x, y;
      x = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
      y = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;

      // Reset held, then lane0/lane1 push of A,B.
      step(1'b0, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
      step(1'b0, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
      step(1'b1, 2'b11, x, y, 2'b00, 1'b0, 1'b0);
      // Fill to 7, then a push while not ready is dropped but the pop happens.
      push2(2'b11);
      push2(2'b11);
      push2(2'b01);
      step(1'b1, 2'b11, x, y, 2'b01, 1'b0, 1'b0);
      step(1'b1, 2'b11, x, y, 2'b00, 1'b0, 1'b0);
      repeat (4) pop(2'b11);
      // Walk the head to slot 7, then straddle the wrap with two entries.
      repeat (3) push2(2'b11);
      repeat (3) pop(2'b11);
      push2(2'b11);
      push2(2'b11);
      push2(2'b11);
      pop(2'b11);
      pop(2'b11);
      pop(2'b11);
      pop(2'b11);
      // Lone lane1 push, then an illegal grant that must not retire.
      step(1'b1, 2'b10, '0, y, 2'b00, 1'b0, 1'b0);
      pop(2'b10);
      pop(2'b01);
      pop(2'b11);
      // Occupancy 5, paused grant with push, then flush with push.
      push2(2'b11);
      push2(2'b11);
      push2(2'b01);
      step(1'b1, 2'b11, rnd_data(), rnd_data(), 2'b11, 1'b1, 1'b0);
      step(1'b1, 2'b11, rnd_data(), rnd_data(), 2'b11, 1'b1, 1'b1);
      pop(2'b00);
      // Asynchronous reset in the middle of a fill.
      push2(2'b11);
      push2(2'b11);
      step(1'b0, 2'b11, rnd_data(), rnd_data(), 2'b11, 1'b0, 1'b0);
      pop(2'b00);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0), 2'($urandom), rnd_data(), rnd_data(),
              2'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
      end
      step(1'b1, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);

      repeat (4) @(posedge clk);
      n_cmp++;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
